// File: rtl/if_fetch_queue.sv
// Instruction fetch: issues sequential PC requests under a credit limit and buffers
// in-order memory responses with their PC in a small queue feeding decode.
module if_fetch_queue #(
  parameter int              PC_W     = 64,
  parameter int              INST_W   = 32,
  parameter int              DEPTH    = 4,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [PC_W-1:0]   imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [INST_W-1:0] imem_rsp_data,
  input  logic              redirect_valid,
  input  logic [PC_W-1:0]   redirect_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] INST,
  output logic [PC_W-1:0]   PCOUT
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW:0]   DEPTH_O = (CW+1)'(DEPTH);

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
  } q_ent_t;

  logic [PC_W-1:0] fetch_pc, rsp_pc, redir_base;
  logic [CW-1:0]   in_flight, discard, count;
  logic [AW-1:0]   rd_ptr, wr_ptr;
  logic [CW:0]     occ;
  logic            req_fire, push, pop;
  q_ent_t          q_mem [DEPTH];
  q_ent_t          head;

  assign redir_base = redirect_pc & ~PC_W'(3);

  // Credit: live in-flight responses plus queued entries must fit in the queue,
  // and the discard counter needs in_flight bounded as well.
  assign occ            = {1'b0, in_flight} - {1'b0, discard} + {1'b0, count};
  assign imem_req_valid = rst && !redirect_valid && (occ < DEPTH_O) && (in_flight < DEPTH_C);
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign inst_valid = (count != '0);
  assign head       = q_mem[rd_ptr];
  assign INST       = inst_valid ? head.inst : '0;
  assign PCOUT      = inst_valid ? head.pc   : '0;

  assign push = imem_rsp_valid && (discard == '0) && !redirect_valid;
  assign pop  = inst_valid && inst_ready && !redirect_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc  <= RESET_PC;
      rsp_pc    <= RESET_PC;
      in_flight <= '0;
      discard   <= '0;
      count     <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
    end else if (redirect_valid) begin
      fetch_pc  <= redir_base;
      rsp_pc    <= redir_base;
      in_flight <= in_flight - CW'(imem_rsp_valid);
      discard   <= in_flight - CW'(imem_rsp_valid);
      count     <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
    end else begin
      if (req_fire) fetch_pc <= fetch_pc + PC_W'(4);
      in_flight <= in_flight + CW'(req_fire) - CW'(imem_rsp_valid);
      if (imem_rsp_valid && discard != '0) discard <= discard - CW'(1);
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
        rsp_pc <= rsp_pc + PC_W'(4);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) q_mem[wr_ptr] <= {rsp_pc, imem_rsp_data};
  end

  // Overflow would mean the credit accounting is broken.
  always @(posedge clk) begin
    if (rst) assert (!(push && count == DEPTH_C && !pop));
  end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed bench for if_fetch_queue: latency-configurable memory model plus a
// scoreboard of expected {PC, INST} pairs pushed on request and checked on pop.
module tb_if_fetch_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req_valid, imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        inst_valid, inst_ready;
  logic [31:0] INST;
  logic [63:0] PCOUT;

  typedef struct { logic [63:0] pc; logic [31:0] inst; } exp_t;
  typedef struct { logic [63:0] a; int due; } mreq_t;

  exp_t        exp_q[$];
  mreq_t       mem_q[$];
  logic [63:0] fire_log[$];
  int n_tests = 0, n_fail = 0, cyc = 0, lat = 1;

  if_fetch_queue #(.PC_W(64), .INST_W(32), .DEPTH(4), .RESET_PC(64'h0)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .INST(INST), .PCOUT(PCOUT)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mdata(input logic [63:0] a);
    return a[31:0] ^ 32'hA5A5_0000;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // One clock: sample, score pops, log requests, then present memory response.
  task automatic cycle();
    logic        fire;
    logic [63:0] a;
    exp_t        e;
    #1;
    fire = imem_req_valid && imem_req_ready;
    a    = imem_req_addr;
    if (inst_valid && inst_ready) begin
      if (exp_q.size() == 0) check("pop_unexpected", 64'(inst_valid), 64'(0));
      else begin
        e = exp_q.pop_front();
        check("pop_pc", PCOUT, e.pc);
        check("pop_inst", 64'(INST), 64'(e.inst));
      end
    end
    if (redirect_valid) exp_q.delete();
    if (fire) begin
      exp_q.push_back('{pc: a, inst: mdata(a)});
      mem_q.push_back('{a: a, due: cyc + lat});
      fire_log.push_back(a);
    end
    @(posedge clk);
    cyc++;
    #1;
    redirect_valid = 1'b0;
    if (mem_q.size() != 0 && mem_q[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mdata(mem_q[0].a);
      void'(mem_q.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; redirect_valid = 1'b0; imem_rsp_valid = 1'b0;
    mem_q.delete(); exp_q.delete(); fire_log.delete();
    repeat (2) @(posedge clk);
    #1;
    check("rst_inst_valid", 64'(inst_valid), 64'(0));
    check("rst_inst", 64'(INST), 64'(0));
    check("rst_pcout", PCOUT, 64'(0));
    check("rst_req_valid", 64'(imem_req_valid), 64'(0));
    rst = 1'b1;
    #1;
  endtask

  task automatic drain(input string tag);
    imem_req_ready = 1'b0; inst_ready = 1'b1;
    repeat (8) cycle();
    check({tag, "_drained"}, 64'(exp_q.size()), 64'(0));
    check({tag, "_idle"}, 64'(inst_valid), 64'(0));
    imem_req_ready = 1'b1;
  endtask

  task automatic wait_inst(input string tag);
    int k = 0;
    while (!inst_valid && k < 20) begin cycle(); k++; end
    check({tag, "_inst_arrives"}, 64'(inst_valid), 64'(1));
  endtask

  initial begin
    imem_req_ready = 1'b1; inst_ready = 1'b1; redirect_valid = 1'b0;
    redirect_pc = '0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;

    // Streaming with 1-cycle memory
    do_reset();
    check("t1_first_req_valid", 64'(imem_req_valid), 64'(1));
    check("t1_first_req_addr", imem_req_addr, 64'(0));
    cycle();
    check("t1_no_inst_yet", 64'(inst_valid), 64'(0));
    cycle();
    check("t1_first_inst_valid", 64'(inst_valid), 64'(1));
    check("t1_first_pcout", PCOUT, 64'(0));
    check("t1_first_inst", 64'(INST), 64'(32'hA5A5_0000));
    repeat (12) cycle();
    drain("t1");

    // Decode stalled: credit limits to 4 requests
    do_reset();
    inst_ready = 1'b0;
    repeat (8) cycle();
    check("t2_req_count", 64'(fire_log.size()), 64'(4));
    check("t2_last_addr", fire_log.size() == 4 ? fire_log[3] : '1, 64'hC);
    check("t2_req_blocked", 64'(imem_req_valid), 64'(0));
    inst_ready = 1'b1;
    repeat (10) cycle();
    check("t2_resume_addr", fire_log.size() > 4 ? fire_log[4] : '1, 64'h10);
    drain("t2");

    // Memory not ready: address held
    do_reset();
    imem_req_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("t3_hold_valid", 64'(imem_req_valid), 64'(1));
      check("t3_hold_addr", imem_req_addr, 64'(0));
      cycle();
    end
    imem_req_ready = 1'b1;
    repeat (10) cycle();
    drain("t3");

    // 3-cycle memory, redirect with 3 requests in flight
    do_reset();
    lat = 3;
    repeat (3) cycle();
    check("t4_rsp_at_redirect", 64'(imem_rsp_valid), 64'(1));
    redirect_valid = 1'b1; redirect_pc = 64'h400;
    cycle();
    check("t4_flushed", 64'(inst_valid), 64'(0));
    check("t4_req_valid", 64'(imem_req_valid), 64'(1));
    check("t4_req_addr", imem_req_addr, 64'h400);
    wait_inst("t4a");
    check("t4_pc0", PCOUT, 64'h400);
    cycle();
    wait_inst("t4b");
    check("t4_pc1", PCOUT, 64'h404);
    repeat (8) cycle();
    drain("t4");
    lat = 1;

    // Redirect coinciding with a response and a pop
    do_reset();
    repeat (4) cycle();
    check("t5_rsp_present", 64'(imem_rsp_valid), 64'(1));
    check("t5_pop_present", 64'(inst_valid), 64'(1));
    redirect_valid = 1'b1; redirect_pc = 64'h803;
    cycle();
    check("t5_flushed", 64'(inst_valid), 64'(0));
    check("t5_req_addr", imem_req_addr, 64'h800);
    wait_inst("t5");
    check("t5_pc0", PCOUT, 64'h800);
    repeat (6) cycle();
    drain("t5");

    // Asynchronous reset mid-stream
    do_reset();
    repeat (5) cycle();
    rst = 1'b0;
    #1;
    check("t6_async_inst_valid", 64'(inst_valid), 64'(0));
    check("t6_async_inst", 64'(INST), 64'(0));
    check("t6_async_pcout", PCOUT, 64'(0));
    check("t6_async_req_valid", 64'(imem_req_valid), 64'(0));
    mem_q.delete(); exp_q.delete(); imem_rsp_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("t6_refetch_addr", imem_req_addr, 64'(0));
    repeat (8) cycle();
    drain("t6");

    // PC wrap at top of address space
    do_reset();
    repeat (3) cycle();
    redirect_valid = 1'b1; redirect_pc = '1;
    cycle();
    check("t7_top_addr", imem_req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    cycle();
    check("t7_wrap_addr", imem_req_addr, 64'h0);
    repeat (6) cycle();
    drain("t7");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
